key_event_master: RTL and testbench

Avalon-MM master that services the 3-key edge-capture PIO slave. After reset it programs the slave's interrupt mask, then on each `irq` it reads the captured edges and the live key levels and clears the capture register. It queues each event as a record in a small FIFO for a valid/ready consumer. It sits beside the key PIO and replaces the Nios II interrupt handler for key events.

---
 rtl/key_evt_pkg.sv | 18 +
 rtl/key_evt_fifo.sv | 53 +++++
 rtl/key_event_master.sv | 120 ++++++++++++
 tb/tb_key_event_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared types and slave register map
// for the key edge-capture service master.
package key_evt_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_EDGE,
    RD_LVL,
    CLR,
    PUSH
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: synchronous FIFO with a combinational
// head and extra pointer bit for full/empty.
module key_evt_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // a pop frees the slot, so a full FIFO still accepts
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_master.sv
// key_event_master: services the key edge-capture PIO
// and queues {level, edges} records for a consumer.
module key_event_master
  import key_evt_pkg::*;
#(
  parameter int               KEY_W      = 3,
  parameter logic [KEY_W-1:0] MASK_INIT  = {KEY_W{1'b1}},
  parameter int               FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [1:0]         m_address,
  output logic               m_chipselect,
  output logic               m_write_n,
  output logic [31:0]        m_writedata,
  input  logic [31:0]        m_readdata,
  input  logic               irq,
  output logic               evt_valid,
  output logic [2*KEY_W-1:0] evt_data,
  input  logic               evt_ready,
  output logic               overflow,
  input  logic               ovf_clr
);

  state_t           state;
  logic [KEY_W-1:0] edges;
  logic [KEY_W-1:0] level;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_rd;

  assign unused_rd = ^m_readdata[31:KEY_W];

  // bus outputs carry the access of the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= INIT;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= ADDR_DATA;
      m_writedata  <= '0;
      edges        <= '0;
      level        <= '0;
    end else begin
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= ADDR_DATA;
      m_writedata  <= '0;
      unique case (state)
        INIT: begin
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_address    <= ADDR_MASK;
          m_writedata  <= 32'(MASK_INIT);
          state        <= IDLE;
        end
        IDLE: begin
          if (irq) begin
            m_chipselect <= 1'b1;
            m_address    <= ADDR_EDGE;
            state        <= RD_EDGE;
          end
        end
        RD_EDGE: begin
          m_chipselect <= 1'b1;
          m_address    <= ADDR_DATA;
          state        <= RD_LVL;
        end
        RD_LVL: begin
          edges        <= m_readdata[KEY_W-1:0];
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_address    <= ADDR_EDGE;
          state        <= CLR;
        end
        CLR: begin
          level <= m_readdata[KEY_W-1:0];
          state <= PUSH;
        end
        PUSH: begin
          state <= IDLE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  assign push_req  = (state == PUSH) && (edges != '0);
  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  key_evt_fifo #(
    .W     (2*KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (pop),
    .wdata   ({level, edges}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (evt_data)
  );

endmodule

// File: tb/tb_key_event_master.sv
// tb_key_event_master: PIO slave model, event-queue model
// and directed scenarios for key_event_master.
module tb_key_event_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        irq;
  logic        evt_valid;
  logic [5:0]  evt_data;
  logic        evt_ready = 1'b0;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_event_master #(
    .KEY_W      (3),
    .MASK_INIT  (3'b111),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .irq          (irq),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  // PIO slave: capture, mask, live levels, latency-1 reads
  logic [2:0] cap;
  logic [2:0] mask_r;
  logic [2:0] lvl_in = 3'b000;
  logic [2:0] inj = 3'b000;
  logic       irq_force = 1'b0;

  assign irq = (|(cap & mask_r)) | irq_force;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap        <= 3'b000;
      mask_r     <= 3'b000;
      m_readdata <= 32'd0;
    end else begin
      if (m_chipselect && m_write_n) begin
        case (m_address)
          2'd3:    m_readdata <= {29'd0, cap};
          2'd2:    m_readdata <= {29'd0, mask_r};
          default: m_readdata <= {29'd0, lvl_in};
        endcase
      end
      if (m_chipselect && !m_write_n && m_address == 2'd2)
        mask_r <= m_writedata[2:0];
      if (m_chipselect && !m_write_n && m_address == 2'd3)
        cap <= inj;
      else
        cap <= cap | inj;
    end
  end

  // event model: a service started by irq samples the capture
  // 1 cycle later, the levels 2 cycles later, and queues 4 later
  logic [5:0] mq[$];
  bit         movf;
  int         svc;
  logic [2:0] me;
  logic [2:0] ml;
  bit         popped;
  bit         ovf_set;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      movf = 1'b0;
      svc  = -1;
      me   = 3'b000;
      ml   = 3'b000;
    end else begin
      popped  = (mq.size() != 0) && evt_ready;
      ovf_set = 1'b0;
      if (svc == 1) me = cap;
      if (svc == 2) ml = lvl_in;
      if (popped) void'(mq.pop_front());
      if (svc == 4 && me != 3'b000) begin
        if (mq.size() < 4) mq.push_back({ml, me});
        else ovf_set = 1'b1;
      end
      if (ovf_set) movf = 1'b1;
      else if (ovf_clr) movf = 1'b0;
      if (svc == -1) svc = 0;
      else if (svc == 0) svc = irq ? 1 : 0;
      else if (svc == 4) svc = 0;
      else svc = svc + 1;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(string name, logic cs, logic wn,
                         logic [1:0] a, logic [31:0] wd);
    chk(name, {m_chipselect, m_write_n, m_address, m_writedata},
        {cs, wn, a, wd});
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_evt_valid", 64'(evt_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("m_evt_data", 64'(evt_data), 64'(mq[0]));
      chk("m_overflow", 64'(overflow), 64'(movf));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic inject(logic [2:0] e, logic [2:0] l);
    lvl_in = l;
    inj    = e;
    @(negedge clk);
    inj    = 3'b000;
  endtask

  logic [2:0] ev_e [5] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101};
  logic [2:0] ev_l [5] = '{3'b100, 3'b000, 3'b111, 3'b001, 3'b010};

  initial begin
    cyc(2);
    chk_bus("rst_bus", 1'b0, 1'b1, 2'd0, 32'd0);
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_data", 64'(evt_data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    cyc(1);
    chk_bus("init_wr", 1'b1, 1'b0, 2'd2, 32'h7);
    cyc(1);
    chk_bus("init_idle", 1'b0, 1'b1, 2'd0, 32'd0);

    cyc(2);
    inject(3'b010, 3'b010);
    cyc(1);
    chk_bus("rd_edge", 1'b1, 1'b1, 2'd3, 32'd0);
    cyc(1);
    chk_bus("rd_lvl", 1'b1, 1'b1, 2'd0, 32'd0);
    cyc(1);
    chk_bus("clr_wr", 1'b1, 1'b0, 2'd3, 32'd0);
    cyc(1);
    chk_bus("push_idle", 1'b0, 1'b1, 2'd0, 32'd0);
    chk("push_valid", 64'(evt_valid), 64'd0);
    cyc(1);
    chk("ev1_valid", 64'(evt_valid), 64'd1);
    chk("ev1_data", 64'(evt_data), 64'b010010);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    chk("ev1_popped", 64'(evt_valid), 64'd0);

    for (int i = 0; i < 5; i++) begin
      inject(ev_e[i], ev_l[i]);
      cyc(6);
    end
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_head", 64'(evt_data), 64'b100001);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    inject(3'b110, 3'b011);
    cyc(4);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    chk("full_pop_ovf", 64'(overflow), 64'd0);
    chk("full_pop_head", 64'(evt_data), 64'b000010);
    evt_ready = 1'b1;
    cyc(4);
    evt_ready = 1'b0;
    chk("drained", 64'(evt_valid), 64'd0);

    cyc(2);
    irq_force = 1'b1;
    cyc(1);
    irq_force = 1'b0;
    chk_bus("spur_rd", 1'b1, 1'b1, 2'd3, 32'd0);
    cyc(6);
    chk("spur_valid", 64'(evt_valid), 64'd0);
    chk("spur_ovf", 64'(overflow), 64'd0);

    inject(3'b001, 3'b001);
    cyc(6);
    chk("pre_rst_valid", 64'(evt_valid), 64'd1);
    inject(3'b100, 3'b000);
    cyc(3);
    chk_bus("mid_clr", 1'b1, 1'b0, 2'd3, 32'd0);
    reset_n = 1'b0;
    #1;
    chk_bus("mid_rst_bus", 1'b0, 1'b1, 2'd0, 32'd0);
    chk("mid_rst_valid", 64'(evt_valid), 64'd0);
    chk("mid_rst_data", 64'(evt_data), 64'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    chk_bus("reinit_wr", 1'b1, 1'b0, 2'd2, 32'h7);
    cyc(1);
    chk_bus("reinit_idle", 1'b0, 1'b1, 2'd0, 32'd0);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
